// File: rtl/regfile_pkg.sv
// Shared constants and the write-request record used by the register-file write queue.
package regfile_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// Bundle of write-request, decoder-issue and forwarding signals around the write queue.
interface regfile_write_queue_if #(
  parameter int DEPTH = 4
);
  import regfile_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              stall;
  logic              dec_en;
  logic [ADDR_W-1:0] dec_addr;
  logic [DATA_W-1:0] dec_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_hit_data;
  logic [CNT_W-1:0]  count;

  modport master (
    output wr_valid, wr_addr, wr_data, stall, rd_addr,
    input  wr_ready, dec_en, dec_addr, dec_data, rd_hit, rd_hit_data, count
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, stall, rd_addr,
    output wr_ready, dec_en, dec_addr, dec_data, rd_hit, rd_hit_data, count
  );

endinterface

// File: rtl/wr_req_fifo.sv
// Circular buffer of pending write requests; slots are exported so the top can search them.
module wr_req_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wr_req_t          push_req,
  input  logic             pop,
  output wr_req_t          head,
  output wr_req_t          slots [DEPTH],
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  wr_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == {CNT_W{1'b0}});
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign slots   = mem;

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

endmodule

// File: rtl/regfile_write_queue.sv
// Write-back queue: buffers requests, issues one per cycle to the address decoder, forwards pending data.
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_write_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wr_req_t          head;
  wr_req_t          slots [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             dec_en_r;
  logic [ADDR_W-1:0] dec_addr_r;
  logic [DATA_W-1:0] dec_data_r;
  logic             fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0] idx;
  logic             match;

  // Writes to the zero register complete the handshake but are never stored.
  assign bus.wr_ready = !reset && !full;
  assign push         = bus.wr_valid && bus.wr_ready && (bus.wr_addr != ZERO_REG);
  assign pop          = !bus.stall && !empty;

  wr_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_req ('{addr: bus.wr_addr, data: bus.wr_data}),
    .pop      (pop),
    .head     (head),
    .slots    (slots),
    .rd_ptr   (rd_ptr),
    .count    (fifo_count),
    .full     (full),
    .empty    (empty)
  );

  // Output stage feeding the decoder; address/data hold between issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_en_r   <= 1'b0;
      dec_addr_r <= {ADDR_W{1'b0}};
      dec_data_r <= {DATA_W{1'b0}};
    end else if (pop) begin
      dec_en_r   <= 1'b1;
      dec_addr_r <= head.addr;
      dec_data_r <= head.data;
    end else begin
      dec_en_r   <= 1'b0;
    end
  end

  // Forwarding search, oldest first (output stage, then FIFO head to tail) so the youngest match wins.
  always_comb begin
    fwd_hit  = bus.dec_en && (dec_addr_r == bus.rd_addr);
    fwd_data = fwd_hit ? dec_data_r : {DATA_W{1'b0}};
    idx      = rd_ptr;
    match    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx      = rd_ptr + PTR_W'(i);
      match    = (CNT_W'(i) < fifo_count) && (slots[idx].addr == bus.rd_addr);
      fwd_data = match ? slots[idx].data : fwd_data;
      fwd_hit  = fwd_hit || match;
    end
  end

  assign bus.rd_hit      = fwd_hit && (bus.rd_addr != ZERO_REG);
  assign bus.rd_hit_data = bus.rd_hit ? fwd_data : {DATA_W{1'b0}};
  assign bus.dec_en      = dec_en_r;
  assign bus.dec_addr    = dec_addr_r;
  assign bus.dec_data    = dec_data_r;
  assign bus.count       = fifo_count;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed self-checking bench for regfile_write_queue with hand-computed expectations.
module tb_regfile_write_queue;
  import regfile_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  regfile_write_queue_if #(.DEPTH(4)) bus ();

  regfile_write_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 5'd0;
    bus.wr_data  = 64'd0;
    bus.stall    = 1'b0;
    bus.rd_addr  = 5'd0;

    // Reset then idle
    tick();
    check("ready_in_reset", bus.wr_ready, 64'd0);
    tick();
    reset = 1'b0;
    bus.rd_addr = 5'd3;
    tick();
    check("idle_dec_en", bus.dec_en, 64'd0);
    check("idle_count", bus.count, 64'd0);
    check("idle_ready", bus.wr_ready, 64'd1);
    check("idle_dec_addr", bus.dec_addr, 64'd0);
    check("idle_dec_data", bus.dec_data, 64'd0);
    check("idle_rd_hit", bus.rd_hit, 64'd0);

    // Single write, two-edge latency
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd5;
    bus.wr_data  = 64'hAA;
    #1;
    check("single_ready", bus.wr_ready, 64'd1);
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_addr  = 5'd5;
    #1;
    check("single_count", bus.count, 64'd1);
    check("single_no_bypass", bus.dec_en, 64'd0);
    check("single_fwd_fifo_hit", bus.rd_hit, 64'd1);
    check("single_fwd_fifo_data", bus.rd_hit_data, 64'hAA);
    tick();
    check("single_dec_en", bus.dec_en, 64'd1);
    check("single_dec_addr", bus.dec_addr, 64'd5);
    check("single_dec_data", bus.dec_data, 64'hAA);
    check("single_count_after", bus.count, 64'd0);
    check("single_fwd_out_hit", bus.rd_hit, 64'd1);
    check("single_fwd_out_data", bus.rd_hit_data, 64'hAA);
    tick();
    check("single_dec_en_drop", bus.dec_en, 64'd0);
    check("single_dec_addr_hold", bus.dec_addr, 64'd5);
    check("single_fwd_gone", bus.rd_hit, 64'd0);
    check("single_fwd_gone_data", bus.rd_hit_data, 64'd0);

    // Stalled burst: fill, back-pressure, drain in order with wrap
    bus.stall = 1'b1;
    for (int a = 1; a <= 4; a++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 5'(a);
      bus.wr_data  = 64'h10 + 64'(a);
      tick();
    end
    bus.wr_addr = 5'd5;
    bus.wr_data = 64'h15;
    #1;
    check("burst_full_ready", bus.wr_ready, 64'd0);
    check("burst_full_count", bus.count, 64'd4);
    tick();
    check("burst_hold_count", bus.count, 64'd4);
    check("burst_hold_dec_en", bus.dec_en, 64'd0);
    bus.rd_addr = 5'd4;
    #1;
    check("burst_fwd_tail", bus.rd_hit_data, 64'h14);
    bus.stall = 1'b0;
    tick();
    check("burst_issue1_en", bus.dec_en, 64'd1);
    check("burst_issue1_addr", bus.dec_addr, 64'd1);
    check("burst_issue1_count", bus.count, 64'd3);
    check("burst_ready_again", bus.wr_ready, 64'd1);
    tick();
    bus.wr_valid = 1'b0;
    check("burst_issue2_addr", bus.dec_addr, 64'd2);
    check("burst_issue2_count", bus.count, 64'd3);
    tick();
    check("burst_issue3_addr", bus.dec_addr, 64'd3);
    check("burst_issue3_count", bus.count, 64'd2);
    tick();
    check("burst_issue4_addr", bus.dec_addr, 64'd4);
    check("burst_issue4_data", bus.dec_data, 64'h14);
    tick();
    check("burst_issue5_en", bus.dec_en, 64'd1);
    check("burst_issue5_addr", bus.dec_addr, 64'd5);
    check("burst_issue5_data", bus.dec_data, 64'h15);
    check("burst_empty_count", bus.count, 64'd0);
    tick();
    check("burst_done_en", bus.dec_en, 64'd0);

    // Zero-register write is consumed and dropped
    bus.wr_valid = 1'b1;
    bus.wr_addr  = ZERO_REG;
    bus.wr_data  = 64'hFF;
    #1;
    check("zero_ready", bus.wr_ready, 64'd1);
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_addr  = ZERO_REG;
    #1;
    check("zero_count", bus.count, 64'd0);
    check("zero_rd_hit", bus.rd_hit, 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("zero_dec_en", bus.dec_en, 64'd0);
    end

    // Same register twice: youngest forwarded, issue in arrival order
    bus.stall    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd7;
    bus.wr_data  = 64'd1;
    tick();
    bus.wr_data  = 64'd2;
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_addr  = 5'd7;
    #1;
    check("dup_count", bus.count, 64'd2);
    check("dup_rd_hit", bus.rd_hit, 64'd1);
    check("dup_rd_hit_data", bus.rd_hit_data, 64'd2);
    bus.stall = 1'b0;
    tick();
    check("dup_issue1_data", bus.dec_data, 64'd1);
    check("dup_mid_fwd_data", bus.rd_hit_data, 64'd2);
    tick();
    check("dup_issue2_en", bus.dec_en, 64'd1);
    check("dup_issue2_data", bus.dec_data, 64'd2);
    check("dup_out_fwd_data", bus.rd_hit_data, 64'd2);
    tick();
    check("dup_done_hit", bus.rd_hit, 64'd0);

    // Reset with three entries queued
    bus.stall    = 1'b1;
    bus.wr_valid = 1'b1;
    for (int a = 8; a <= 10; a++) begin
      bus.wr_addr = 5'(a);
      bus.wr_data = 64'(a);
      tick();
    end
    bus.wr_valid = 1'b0;
    check("pre_reset_count", bus.count, 64'd3);
    reset = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd12;
    #1;
    check("reset_ready_low", bus.wr_ready, 64'd0);
    tick();
    reset        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.stall    = 1'b0;
    bus.rd_addr  = 5'd9;
    #1;
    check("post_reset_count", bus.count, 64'd0);
    check("post_reset_dec_en", bus.dec_en, 64'd0);
    check("post_reset_dec_addr", bus.dec_addr, 64'd0);
    check("post_reset_rd_hit", bus.rd_hit, 64'd0);
    tick();
    check("post_reset_no_issue", bus.dec_en, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
